// File: rtl/int_square.sv
// Sequential integer squarer: radix-2 shift-add, one multiplier bit per clock.
// Companion to the integer square-root unit; a fixed WIDTH-cycle latency per operation.
module int_square #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               Clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   num_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] square
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   square_q, square_d;

  // Partial-product sum for this iteration; a square never overflows 2*WIDTH bits.
  logic [2*WIDTH-1:0]   acc_sum;
  assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Next-state and datapath control; everything holds unless a branch says otherwise.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    square_d = square_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, num_in};
          mplier_d = num_in;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          // Final iteration: publish including this cycle's add.
          square_d = acc_sum;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          cnt_d    = '0;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-high reset; reset also aborts a running operation.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      square_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      square_q <= square_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign square = square_q;

endmodule
